// File: rtl/keypad_pkg.sv
// Shared types, key map and timing helper for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    DRIVE,
    SAMPLE,
    EVAL
  } scan_st_e;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } sweep_e;

  // Indexed [row][col]
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  function automatic int unsigned ms_to_cycles(
    input int unsigned clk_freq,
    input int unsigned ms
  );
    return clk_freq / 1000 * ms;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad pin and key-report bundle.
// master = scanner side, slave = keypad/consumer side.
interface keypad_if;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi_key;

  modport master (
    output col, key_code, key_valid, key_held, multi_key,
    input  row
  );

  modport slave (
    input  col, key_code, key_valid, key_held, multi_key,
    output row
  );
endinterface

// File: rtl/keypad_sync.sv
// 2-flop synchroniser for the asynchronous row returns.
// Resets to all-high (no key pressed).
module keypad_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);
  logic [3:0] m_q;
  logic [3:0] s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= 4'hF;
      s_q <= 4'hF;
    end else begin
      m_q <= d_i;
      s_q <= m_q;
    end
  end

  assign q_o = s_q;
endmodule

// File: rtl/keypad_scanner.sv
// Column-strobe 4x4 keypad scanner with whole-sweep debounce.
// Define KEYPAD_REPEAT_EN to build key auto-repeat.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned clk_freq      = 125_000_000,
  parameter int unsigned stable_time   = 10,
  parameter int unsigned settle_cycles = 125,
  parameter int unsigned repeat_ms     = 250
) (
  input  logic     clk,
  input  logic     rst,
  keypad_if.master kp
);

  localparam int unsigned THR = ms_to_cycles(clk_freq, stable_time);
  localparam int CW = $clog2(THR + 1);
  localparam int SW = $clog2(settle_cycles + 1);
  localparam logic [CW-1:0] THR_C = CW'(THR);
  localparam logic [SW-1:0] SET_LAST = SW'(settle_cycles - 1);

  scan_st_e      st_q, st_d;
  logic [1:0]    c_q, c_d;
  logic [SW-1:0] set_q, set_d;
  logic [3:0]    col_q, col_d;
  logic [3:0]    row_s;

  logic [1:0]    lows_q, lows_d;
  logic [3:0]    acode_q, acode_d;

  sweep_e        res;
  logic [3:0]    res_code;
  sweep_e        cand_q, cand_d;
  logic [3:0]    ccode_q, ccode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fire;

  logic [3:0]    code_q, code_d;
  logic          kv_q, kv_d;
  logic          held_q, held_d;
  logic          multi_q, multi_d;
  logic          rep_q, rep_d;
  logic          rpt_fire;

  keypad_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (kp.row),
    .q_o (row_s)
  );

  always_comb begin
    st_d  = st_q;
    c_d   = c_q;
    set_d = set_q;
    unique case (st_q)
      DRIVE: begin
        if (set_q == SET_LAST) begin
          st_d  = SAMPLE;
          set_d = '0;
        end else begin
          set_d = set_q + 1'b1;
        end
      end
      SAMPLE: begin
        c_d  = c_q + 2'd1;
        st_d = (c_q == 2'd3) ? EVAL : DRIVE;
      end
      EVAL:    st_d = DRIVE;
      default: st_d = DRIVE;
    endcase
    col_d = (st_d == EVAL) ? 4'hF : ~(4'b0001 << c_d);
  end

  // Low-row count saturates at 2: anything beyond one key is MULTI
  always_comb begin
    lows_d  = lows_q;
    acode_d = acode_q;
    if (st_q == EVAL) begin
      lows_d  = '0;
      acode_d = '0;
    end else if (st_q == SAMPLE) begin
      for (int r = 0; r < 4; r++) begin
        if (!row_s[r]) begin
          if (lows_d != 2'd2) lows_d = lows_d + 2'd1;
          acode_d = KEY_MAP[r][c_q];
        end
      end
    end
  end

  always_comb begin
    res      = NONE;
    res_code = '0;
    if (lows_q == 2'd1) begin
      res      = SINGLE;
      res_code = acode_q;
    end else if (lows_q == 2'd2) begin
      res = MULTI;
    end
  end

  always_comb begin
    cand_d  = cand_q;
    ccode_d = ccode_q;
    if (st_q == EVAL && (res != cand_q || res_code != ccode_q)) begin
      cand_d  = res;
      ccode_d = res_code;
      cnt_d   = '0;
    end else if (cnt_q == THR_C) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    fire = (cnt_q != THR_C) && (cnt_d == THR_C);
  end

  always_comb begin
    code_d  = code_q;
    kv_d    = 1'b0;
    held_d  = held_q;
    multi_d = multi_q;
    rep_d   = rep_q;
    if (fire) begin
      unique case (1'b1)
        (cand_q == SINGLE) && (!rep_q || ccode_q != code_q): begin
          code_d  = ccode_q;
          kv_d    = 1'b1;
          held_d  = 1'b1;
          rep_d   = 1'b1;
          multi_d = 1'b0;
        end
        (cand_q == SINGLE) && rep_q && (ccode_q == code_q): begin
          multi_d = 1'b0;
        end
        (cand_q == NONE): begin
          held_d  = 1'b0;
          multi_d = 1'b0;
          rep_d   = 1'b0;
        end
        (cand_q == MULTI): begin
          multi_d = 1'b1;
        end
        default: ;
      endcase
    end
    if (rpt_fire) kv_d = 1'b1;
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RPT = ms_to_cycles(clk_freq, repeat_ms);
  localparam int RW = $clog2(RPT + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(RPT - 1);

  logic [RW-1:0] rpt_q, rpt_d;

  // Timer only runs while the reported key is still the stable candidate
  always_comb begin
    rpt_d    = '0;
    rpt_fire = 1'b0;
    if (held_q && cand_q == SINGLE && ccode_q == code_q && !fire) begin
      if (rpt_q == RPT_LAST) begin
        rpt_fire = 1'b1;
      end else begin
        rpt_d = rpt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rpt_q <= '0;
    else     rpt_q <= rpt_d;
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= DRIVE;
      c_q     <= '0;
      set_q   <= '0;
      col_q   <= 4'hF;
      lows_q  <= '0;
      acode_q <= '0;
      cand_q  <= NONE;
      ccode_q <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      kv_q    <= 1'b0;
      held_q  <= 1'b0;
      multi_q <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      c_q     <= c_d;
      set_q   <= set_d;
      col_q   <= col_d;
      lows_q  <= lows_d;
      acode_q <= acode_d;
      cand_q  <= cand_d;
      ccode_q <= ccode_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      kv_q    <= kv_d;
      held_q  <= held_d;
      multi_q <= multi_d;
      rep_q   <= rep_d;
    end
  end

  assign kp.col       = col_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = kv_q;
  assign kp.key_held  = held_q;
  assign kp.multi_key = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
// Build with KEYPAD_REPEAT_EN to expect auto-repeat pulses.
module tb_keypad_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0][3:0] pressed = '0;
  logic [3:0] row_m;

  int tests = 0;
  int fails = 0;
  int nvalid = 0;
  logic [3:0] vcode = '0;

  keypad_if kif ();

  keypad_scanner #(
    .clk_freq      (1_000_000),
    .stable_time   (1),
    .settle_cycles (8),
    .repeat_ms     (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif)
  );

  always #5 clk = ~clk;

  // Pressed switch shorts row r to column c
  always_comb begin
    row_m = 4'hF;
    for (int r = 0; r < 4; r++) row_m[r] = ~|(pressed[r] & ~kif.col);
  end
  assign kif.row = row_m;

  always @(posedge clk) begin
    #1;
    if (kif.key_valid === 1'b1) begin
      nvalid = nvalid + 1;
      vcode  = kif.key_code;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    int r;
    int c;
    logic [3:0] code;
  } vec_t;

  vec_t vecs [16];

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input int maxc, output int got);
    int n0;
    int w;
    n0 = nvalid;
    got = 0;
    w = 0;
    while (got == 0 && w < maxc) begin
      @(negedge clk);
      w++;
      if (nvalid != n0) got = 1;
    end
  endtask

  initial begin
    int got;
    int n0;
    int k;
    int ok;
    int exp_rpt;
    logic [3:0] ecol;

    vecs[0]  = '{0, 0, 4'h1};
    vecs[1]  = '{0, 1, 4'h2};
    vecs[2]  = '{0, 2, 4'h3};
    vecs[3]  = '{0, 3, 4'hA};
    vecs[4]  = '{1, 0, 4'h4};
    vecs[5]  = '{1, 1, 4'h5};
    vecs[6]  = '{1, 2, 4'h6};
    vecs[7]  = '{1, 3, 4'hB};
    vecs[8]  = '{2, 0, 4'h7};
    vecs[9]  = '{2, 1, 4'h8};
    vecs[10] = '{2, 2, 4'h9};
    vecs[11] = '{2, 3, 4'hC};
    vecs[12] = '{3, 0, 4'h0};
    vecs[13] = '{3, 1, 4'hF};
    vecs[14] = '{3, 2, 4'hE};
    vecs[15] = '{3, 3, 4'hD};
`ifdef KEYPAD_REPEAT_EN
    exp_rpt = 2;
`else
    exp_rpt = 0;
`endif

    cyc(3);
    chk("rst_col", kif.col, 4'hF);
    chk("rst_valid", kif.key_valid, 0);
    chk("rst_held", kif.key_held, 0);
    chk("rst_multi", kif.multi_key, 0);
    chk("rst_code", kif.key_code, 0);
    rst = 1'b0;

    k = 0;
    while (kif.col == 4'hF && k < 100) begin @(negedge clk); k++; end
    while (kif.col != 4'hF && k < 200) begin @(negedge clk); k++; end
    chk("sweep_eval0", kif.col, 4'hF);
    for (int c = 0; c < 4; c++) begin
      ecol = 4'b0001 << c;
      ecol = ~ecol;
      ok = 1;
      for (int i = 0; i < 9; i++) begin
        @(negedge clk);
        if (kif.col !== ecol) ok = 0;
      end
      chk($sformatf("sweep_col%0d", c), ok, 1);
    end
    @(negedge clk);
    chk("sweep_eval1", kif.col, 4'hF);

    for (int i = 0; i < 16; i++) begin
      pressed = '0;
      pressed[vecs[i].r][vecs[i].c] = 1'b1;
      wait_valid(1200, got);
      chk($sformatf("v%0d_valid", i), got, 1);
      chk($sformatf("v%0d_code", i), vcode, vecs[i].code);
      chk($sformatf("v%0d_held", i), kif.key_held, 1);
      n0 = nvalid;
      pressed = '0;
      cyc(1200);
      chk($sformatf("v%0d_rel_held", i), kif.key_held, 0);
      chk($sformatf("v%0d_rel_code", i), kif.key_code, vecs[i].code);
      chk($sformatf("v%0d_rel_extra", i), nvalid - n0, 0);
    end

    n0 = nvalid;
    for (int i = 0; i < 300; i++) begin
      pressed[1][1] = ((i / 7) % 2 == 0);
      @(negedge clk);
    end
    pressed[1][1] = 1'b1;
    cyc(650);
    chk("bounce_early", nvalid - n0, 0);
    wait_valid(500, got);
    chk("bounce_valid", got, 1);
    chk("bounce_code", vcode, 4'h5);
    chk("bounce_held", kif.key_held, 1);
    n0 = nvalid;
    cyc(10050);
    chk("hold_repeats", nvalid - n0, exp_rpt);
    chk("hold_code", kif.key_code, 4'h5);
    pressed = '0;
    cyc(1200);
    chk("hold_rel_held", kif.key_held, 0);

    n0 = nvalid;
    pressed[0][0] = 1'b1;
    pressed[3][3] = 1'b1;
    cyc(1200);
    chk("multi_flag", kif.multi_key, 1);
    chk("multi_novalid", nvalid - n0, 0);
    chk("multi_held", kif.key_held, 0);
    pressed[3][3] = 1'b0;
    wait_valid(1200, got);
    chk("multi_rel_valid", got, 1);
    chk("multi_rel_code", vcode, 4'h1);
    chk("multi_rel_flag", kif.multi_key, 0);
    pressed = '0;
    cyc(1200);
    chk("all_rel_held", kif.key_held, 0);
    chk("all_rel_code", kif.key_code, 4'h1);
    chk("all_rel_multi", kif.multi_key, 0);

    n0 = nvalid;
    pressed[0][3] = 1'b1;
    cyc(500);
    rst = 1'b1;
    cyc(3);
    chk("midrst_code", kif.key_code, 0);
    chk("midrst_col", kif.col, 4'hF);
    rst = 1'b0;
    cyc(950);
    chk("midrst_novalid", nvalid - n0, 0);
    wait_valid(300, got);
    chk("midrst_valid", got, 1);
    chk("midrst_code_a", vcode, 4'hA);
    pressed = '0;
    cyc(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
